// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// Optional feature macro used by the design: PC_MISALIGN_CHK_EN.
package pc_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    EXC  = 2'd2
  } state_t;

  // Next-PC source chosen on a fire
  typedef enum logic [2:0] {
    SEL_INC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_ERET = 3'd4
  } sel_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0800;
  localparam int          DEF_BOOT_WAIT = 2;

  // BEQ is taken when equal, BNE when not equal
  function automatic logic branch_taken(input logic branch, input logic bne_or_beq,
                                        input logic equal);
    return branch & (equal ^ bne_or_beq);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request handshake between the PC sequencer (master) and instruction fetch (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pc_ready;

  modport master (output pc, output pc_valid, input pc_ready);
  modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_target_sel.sv
// Combinational next-PC selector: priority ERET > JR > J > taken branch > PC+4.
// Register targets (JR/ERET) are word-aligned on the way out; the raw low bits
// are reported through misaligned so the top can trap on them when
// PC_MISALIGN_CHK_EN is defined.
module pc_target_sel
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              is_eret,
  input  logic              is_jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              jump,
  input  logic [25:0]       jump_idx,
  input  logic              branch,
  input  logic              bne_or_beq,
  input  logic              equal,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] next_pc,
  output sel_t              sel,
  output logic              misaligned
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jump_tgt;

  assign pc4    = pc + ADDR_W'(4);
  assign br_tgt = pc4 + (br_offset << 2);

  // Jump keeps the upper PC+4 region bits when the PC is wider than the 28-bit jump span
  generate
    if (ADDR_W > 28) begin : g_jump_wide
      assign jump_tgt = {pc4[ADDR_W-1:28], jump_idx, 2'b00};
    end else begin : g_jump_narrow
      logic [27:0] jump_full;
      assign jump_full = {jump_idx, 2'b00};
      assign jump_tgt  = jump_full[ADDR_W-1:0];
    end
  endgenerate

  // Misalignment only matters for the register target that actually wins priority
  assign misaligned = is_eret ? (epc[1:0] != 2'b00)
                    : is_jr   ? (jr_target[1:0] != 2'b00)
                    : 1'b0;

  // Priority selection of the next fetch address
  always_comb begin
    sel     = SEL_INC;
    next_pc = pc4;
    if (is_eret) begin
      sel     = SEL_ERET;
      next_pc = {epc[ADDR_W-1:2], 2'b00};
    end else if (is_jr) begin
      sel     = SEL_JR;
      next_pc = {jr_target[ADDR_W-1:2], 2'b00};
    end else if (jump) begin
      sel     = SEL_J;
      next_pc = jump_tgt;
    end else if (branch_taken(branch, bne_or_beq, equal)) begin
      sel     = SEL_BR;
      next_pc = br_tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot delay, fetch handshake, next-PC update on
// fire, one-cycle exception-entry bubble that hands EPC to COP0, fetch counter.
// Optional macro PC_MISALIGN_CHK_EN: misaligned JR/ERET targets trap into the
// exception path and pulse the extra misalign output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int                BOOT_WAIT = DEF_BOOT_WAIT,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_sequencer_if.master    fetch,
  input  logic              has_exp,
  input  logic              is_eret,
  input  logic              is_jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              jump,
  input  logic [25:0]       jump_idx,
  input  logic              branch,
  input  logic              bne_or_beq,
  input  logic              equal,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] epc_out,
  output logic              epc_we,
  output logic [CNT_W-1:0]  fetch_cnt
`ifdef PC_MISALIGN_CHK_EN
  ,output logic             misalign
`endif
);

  localparam int BW = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_WAIT - 1);

  state_t            state_reg;
  logic [BW-1:0]     boot_cnt_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              pc_valid_reg;
  logic [ADDR_W-1:0] epc_out_reg;
  logic              epc_we_reg;
  logic [CNT_W-1:0]  fetch_cnt_reg;
  logic              misalign_reg;

  logic [ADDR_W-1:0] next_pc;
  sel_t              sel;
  logic              misaligned;
  logic              fire;
  logic              misalign_hit;

  pc_target_sel #(.ADDR_W(ADDR_W)) u_target_sel (
    .pc         (pc_reg),
    .is_eret    (is_eret),
    .is_jr      (is_jr),
    .jr_target  (jr_target),
    .jump       (jump),
    .jump_idx   (jump_idx),
    .branch     (branch),
    .bne_or_beq (bne_or_beq),
    .equal      (equal),
    .br_offset  (br_offset),
    .epc        (epc),
    .next_pc    (next_pc),
    .sel        (sel),
    .misaligned (misaligned)
  );

  // pc_valid is only ever high in RUN, so fire implies RUN
  assign fire = pc_valid_reg & fetch.pc_ready;

`ifdef PC_MISALIGN_CHK_EN
  assign misalign_hit = fire & misaligned & ((sel == SEL_JR) | (sel == SEL_ERET));
  assign misalign     = misalign_reg;
`else
  // Without the check, register targets are silently word-aligned by the selector
  logic unused_sel;
  assign unused_sel   = ^{sel, misaligned};
  assign misalign_hit = 1'b0;
`endif

  assign fetch.pc       = pc_reg;
  assign fetch.pc_valid = pc_valid_reg;
  assign epc_out        = epc_out_reg;
  assign epc_we         = epc_we_reg;
  assign fetch_cnt      = fetch_cnt_reg;

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= BOOT;
      boot_cnt_reg  <= '0;
      pc_reg        <= RESET_VEC;
      pc_valid_reg  <= 1'b0;
      epc_out_reg   <= '0;
      epc_we_reg    <= 1'b0;
      fetch_cnt_reg <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          // Exceptions are not accepted until fetch starts
          if (boot_cnt_reg == BOOT_LAST) begin
            state_reg    <= RUN;
            pc_valid_reg <= 1'b1;
          end else begin
            boot_cnt_reg <= boot_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (has_exp || misalign_hit) begin
            // Trap: the current pc is the faulting one, whether or not it fired
            state_reg    <= EXC;
            pc_reg       <= EXC_VEC;
            pc_valid_reg <= 1'b0;
            epc_out_reg  <= pc_reg;
            epc_we_reg   <= 1'b1;
            misalign_reg <= misalign_hit;
          end else if (fire) begin
            pc_reg        <= next_pc;
            fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
          end
        end
        EXC: begin
          // Single bubble; a new exception request here is dropped (no nesting)
          state_reg    <= RUN;
          pc_valid_reg <= 1'b1;
          epc_we_reg   <= 1'b0;
          misalign_reg <= 1'b0;
        end
        default: begin
          state_reg    <= BOOT;
          boot_cnt_reg <= '0;
          pc_valid_reg <= 1'b0;
          epc_we_reg   <= 1'b0;
          misalign_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
